// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: FSM states,
// default widths and bit offsets of the fields packed into the control word.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NFIELD = 4;
    localparam int DEF_CTRL_W = 10;
    localparam int DEF_CNT_W  = 16;

    // Control word layout: {RegWriteAddr[4:0], MemWrite, MemRead, MemtoReg[1:0], RegWrite}
    localparam int CTRL_REGWRITE     = 0;
    localparam int CTRL_MEMTOREG_LSB = 1;
    localparam int CTRL_MEMTOREG_W   = 2;
    localparam int CTRL_MEMREAD      = 3;
    localparam int CTRL_MEMWRITE     = 4;
    localparam int CTRL_RWADDR_LSB   = 5;
    localparam int CTRL_RWADDR_W     = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage slot of the stage: an enable-loaded ctrl+payload register whose
// control bits can be cleared independently of the payload.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W    = DEF_CTRL_W,
    parameter int PAYLOAD_W = DEF_DATA_W * DEF_NFIELD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 clear,
    input  logic [CTRL_W-1:0]    d_ctrl,
    input  logic [PAYLOAD_W-1:0] d_data,
    output logic [CTRL_W-1:0]    q_ctrl,
    output logic [PAYLOAD_W-1:0] q_data
);

    // Clearing only the control bits is enough to neutralise a killed entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_ctrl <= '0;
            q_data <= '0;
        end else if (clear) begin
            q_ctrl <= '0;
        end else if (load) begin
            q_ctrl <= d_ctrl;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry (head + skid) pipeline register stage with fully registered
// handshakes, flush, bubble-zeroed control outputs and a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NFIELD = DEF_NFIELD,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [NFIELD*DATA_W-1:0] in_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [NFIELD*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int PAYLOAD_W = NFIELD * DATA_W;

    pipe_state_e state;
    pipe_state_e state_n;
    logic        vld_p1;
    logic        rdy_p1;

    logic push;
    logic pop;
    logic h_load;
    logic s_load;
    logic h_from_s;

    logic [CTRL_W-1:0]    h_ctrl;
    logic [PAYLOAD_W-1:0] h_data;
    logic [CTRL_W-1:0]    s_ctrl;
    logic [PAYLOAD_W-1:0] s_data;
    logic [CTRL_W-1:0]    h_d_ctrl;
    logic [PAYLOAD_W-1:0] h_d_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign push = in_valid & rdy_p1;
    assign pop  = vld_p1 & out_ready;

    always_comb begin
        state_n  = state;
        h_load   = 1'b0;
        s_load   = 1'b0;
        h_from_s = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    h_load  = 1'b1;
                    state_n = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    h_load = 1'b1;
                end else if (push) begin
                    s_load  = 1'b1;
                    state_n = FULL;
                end else if (pop) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    h_load   = 1'b1;
                    h_from_s = 1'b1;
                    state_n  = ONE;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
        if (flush) begin
            state_n  = EMPTY;
            h_load   = 1'b0;
            s_load   = 1'b0;
            h_from_s = 1'b0;
        end
    end

    assign h_d_ctrl = h_from_s ? s_ctrl : in_ctrl;
    assign h_d_data = h_from_s ? s_data : in_data;

    // Handshake outputs are registered from the next state, so nothing on in_* reaches out_*.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            vld_p1 <= 1'b0;
            rdy_p1 <= 1'b1;
        end else begin
            state  <= state_n;
            vld_p1 <= (state_n != EMPTY);
            rdy_p1 <= (state_n != FULL);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (flush) begin
            stall_cnt <= '0;
        end else if (vld_p1 && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    pipe_entry_reg #(
        .CTRL_W    (CTRL_W),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_head (
        .clk    (clk),
        .reset  (reset),
        .load   (h_load),
        .clear  (flush),
        .d_ctrl (h_d_ctrl),
        .d_data (h_d_data),
        .q_ctrl (h_ctrl),
        .q_data (h_data)
    );

    pipe_entry_reg #(
        .CTRL_W    (CTRL_W),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (s_load),
        .clear  (flush),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .q_ctrl (s_ctrl),
        .q_data (s_data)
    );

    // A bubble must never present a live write enable downstream.
    assign in_ready  = rdy_p1;
    assign out_valid = vld_p1;
    assign out_ctrl  = vld_p1 ? h_ctrl : '0;
    assign out_data  = h_data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a queue-based reference model checked every
// cycle, plus literal expectations for streaming, backpressure, flush, stall and reset.
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int NFIELD = 4;
    localparam int CTRL_W = 10;
    localparam int CNT_W  = 4;
    localparam int W      = NFIELD * DATA_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [W-1:0]      in_data = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [W-1:0]      out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [CTRL_W-1:0] mq_ctrl[$];
    logic [W-1:0]      mq_data[$];
    int                mcnt = 0;

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .NFIELD (NFIELD),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk_data(input int v);
        logic [W-1:0] d;
        for (int k = 0; k < NFIELD; k++) begin
            d[k*DATA_W +: DATA_W] = DATA_W'(v + (k << 8));
        end
        return d;
    endfunction

    task automatic drive(input bit v, input logic [CTRL_W-1:0] c, input int d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = mk_data(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of at most two entries plus a saturating stall count.
    always @(posedge clk or negedge reset) begin
        int sz;
        bit do_push;
        bit do_pop;
        if (!reset) begin
            mq_ctrl.delete();
            mq_data.delete();
            mcnt = 0;
        end else begin
            sz      = mq_ctrl.size();
            do_push = in_valid && (sz < 2);
            do_pop  = (sz > 0) && out_ready;
            if (flush) begin
                mq_ctrl.delete();
                mq_data.delete();
                mcnt = 0;
            end else begin
                if (sz > 0 && !out_ready && mcnt < CNT_MAX) mcnt++;
                if (do_pop) begin
                    void'(mq_ctrl.pop_front());
                    void'(mq_data.pop_front());
                end
                if (do_push) begin
                    mq_ctrl.push_back(in_ctrl);
                    mq_data.push_back(in_data);
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = (mq_ctrl.size() > 0);
            check("model_out_valid", W'(out_valid), W'(ev));
            check("model_in_ready", W'(in_ready), W'(mq_ctrl.size() < 2));
            check("model_out_ctrl", W'(out_ctrl), ev ? W'(mq_ctrl[0]) : '0);
            check("model_stall_cnt", W'(stall_cnt), W'(mcnt));
            if (ev) check("model_out_data", out_data, mq_data[0]);
        end
    end

    initial begin
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_ctrl", W'(out_ctrl), W'(0));
        check("rst_stall", W'(stall_cnt), W'(0));

        // Bubble with live-looking control on the input
        drive(1'b0, 10'h3FF, 32'h99);
        repeat (3) tick();
        check("bubble_ctrl", W'(out_ctrl), W'(0));
        check("bubble_valid", W'(out_valid), W'(0));

        // Streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 10'h3FF, i);
            tick();
            check("stream_valid", W'(out_valid), W'(1));
            check("stream_data", W'(out_data[DATA_W-1:0]), W'(i));
            check("stream_ctrl", W'(out_ctrl), W'(10'h3FF));
            check("stream_ready", W'(in_ready), W'(1));
        end
        drive(1'b0, 10'h0, 0);
        tick();
        check("stream_drain", W'(out_valid), W'(0));

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 10'h011, 32'h11);
        tick();
        drive(1'b1, 10'h022, 32'h22);
        tick();
        check("bp_full_ready", W'(in_ready), W'(0));
        check("bp_head_a", W'(out_data[DATA_W-1:0]), W'(32'h11));
        drive(1'b1, 10'h033, 32'h33);
        tick();
        tick();
        check("bp_held_ready", W'(in_ready), W'(0));
        check("bp_held_head", W'(out_data[DATA_W-1:0]), W'(32'h11));
        check("bp_held_ctrl", W'(out_ctrl), W'(10'h011));
        drive(1'b0, 10'h0, 0);
        out_ready = 1'b1;
        check("bp_out_a", W'(out_data[DATA_W-1:0]), W'(32'h11));
        tick();
        check("bp_out_b", W'(out_data[DATA_W-1:0]), W'(32'h22));
        check("bp_out_b_valid", W'(out_valid), W'(1));
        tick();
        check("bp_empty", W'(out_valid), W'(0));

        // Flush while FULL with a simultaneous push of C
        out_ready = 1'b0;
        drive(1'b1, 10'h011, 32'h11);
        tick();
        drive(1'b1, 10'h022, 32'h22);
        tick();
        drive(1'b1, 10'h033, 32'h33);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 10'h0, 0);
        check("flush_valid", W'(out_valid), W'(0));
        check("flush_ctrl", W'(out_ctrl), W'(0));
        check("flush_stall", W'(stall_cnt), W'(0));
        out_ready = 1'b1;
        repeat (3) tick();
        check("flush_no_c", W'(out_valid), W'(0));

        // Flush from ONE discards the same-cycle push
        drive(1'b1, 10'h055, 32'h55);
        tick();
        drive(1'b1, 10'h066, 32'h66);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 10'h0, 0);
        check("flush_one_valid", W'(out_valid), W'(0));
        tick();
        check("flush_one_after", W'(out_valid), W'(0));

        // Stall counter saturation
        out_ready = 1'b0;
        drive(1'b1, 10'h077, 32'h77);
        tick();
        drive(1'b0, 10'h0, 0);
        repeat (20) tick();
        check("stall_sat", W'(stall_cnt), W'(15));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("stall_clr", W'(stall_cnt), W'(0));

        // Asynchronous reset while FULL
        drive(1'b1, 10'h011, 32'h11);
        tick();
        drive(1'b1, 10'h022, 32'h22);
        tick();
        drive(1'b0, 10'h0, 0);
        check("ar_full", W'(in_ready), W'(0));
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("ar_valid", W'(out_valid), W'(0));
        check("ar_ready", W'(in_ready), W'(1));
        check("ar_ctrl", W'(out_ctrl), W'(0));
        check("ar_data", out_data, '0);
        check("ar_stall", W'(stall_cnt), W'(0));
        #4;
        reset = 1'b1;
        drive(1'b1, 10'h044, 32'h44);
        tick();
        drive(1'b0, 10'h0, 0);
        check("ar_d_valid", W'(out_valid), W'(1));
        check("ar_d_data", W'(out_data[DATA_W-1:0]), W'(32'h44));
        out_ready = 1'b1;
        repeat (2) tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of one datapath payload field.
REQ-002 Parameter NFIELD, default 4, number of DATA_W payload fields carried, e.g. PCplus4, ReadData2, ALUout, spare.
REQ-003 Parameter CTRL_W, default 10, control-bit width: RegWrite, MemtoReg[1:0], MemRead, MemWrite, RegWriteAddr[4:0].
REQ-004 Parameter CNT_W, default 16, stall-counter width.
REQ-005 clk  in  1  single clock; all state changes on posedge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  upstream stage holds a valid instruction.
REQ-008 in_ready  out  1  stage can accept a push this cycle.
REQ-009 in_ctrl  in  CTRL_W  upstream control bits.
REQ-010 in_data  in  NFIELD*DATA_W  upstream payload, field 0 in LSBs.
REQ-011 flush  in  1  synchronous kill of all held entries.
REQ-012 out_valid  out  1  head entry valid.
REQ-013 out_ready  in  1  downstream accepts head this cycle.
REQ-014 out_ctrl  out  CTRL_W  head control bits; all-zero whenever out_valid=0 (bubble).
REQ-015 out_data  out  NFIELD*DATA_W  head payload; value don't-care when out_valid=0.
REQ-016 stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-018 Storage: two entries, head (H) and skid (S), each holding ctrl+data; no combinational path from in_* to out_*.
REQ-019 State machine EMPTY, ONE, FULL; in_ready = (state != FULL), driven from a register.
REQ-020 EMPTY: push -> load H, go to ONE.
REQ-021 ONE: push & pop -> load H, stay ONE; push only -> load S, go FULL; pop only -> go EMPTY.
REQ-022 FULL: pop -> move S to H, go ONE; push cannot occur.
REQ-023 Latency: a push into EMPTY is visible on out_* the next cycle; throughput is one entry per cycle while out_ready=1.
REQ-024 Ordering is strictly FIFO; no entry is dropped or duplicated except by flush.
REQ-025 flush=1 -> next state EMPTY, H and S control bits zeroed, and any same-cycle push discarded; flush has priority over push and pop.
REQ-026 While out_valid=0, out_ctrl is forced to zero so that a downstream write enable can never assert on a bubble.
REQ-027 stall_cnt increments by 1 per cycle with out_valid & !out_ready, saturates at 2^CNT_W-1, and is cleared by flush.

Reset
REQ-028 reset=0 asynchronously forces state EMPTY, out_valid=0, in_ready=1, out_ctrl=0, out_data=0, H=S=0, and stall_cnt=0.
REQ-029 Reset asserted mid-transfer discards all entries; the first posedge after reset deassertion may accept a push.

Structure
REQ-030 Shared package pipe_pkg holds the state enum (EMPTY/ONE/FULL), default widths, and the control-field bit offsets.
REQ-031 A single sub-module, pipe_entry_reg, implements one enable-loaded ctrl+data register; it is instanced twice (H, S).

Verification
REQ-032 Streaming: out_ready=1, push ctrl=0x3FF and data 0x1..0x8 on consecutive cycles -> identical sequence appears one cycle later with no gaps, and in_ready stays 1.
REQ-033 Backpressure: out_ready=0, push A=0x11 then B=0x22 -> state FULL, in_ready=0, and the third push is held off; set out_ready=1 -> A then B on consecutive cycles.
REQ-034 Flush: FULL with A,B plus simultaneous flush and push C -> next cycle out_valid=0, out_ctrl=0, and C is never output.
REQ-035 Stall counter: CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); flush -> 0.
REQ-036 Async reset: drop reset mid-cycle while FULL -> outputs reach reset values before the next posedge; after release, push D=0x44 -> out_data=0x44 on the following cycle.
REQ-037 Bubble: in_valid=0 with in_ctrl=0x3FF held -> out_ctrl remains 0 and out_valid remains 0.
